// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the I/D-cache physical-memory arbiter.
package pmem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 256;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_e;

  function automatic logic [1:0] req_onehot(input req_e r);
    return (r == REQ_D) ? 2'b10 : 2'b01;
  endfunction

  function automatic req_e other_req(input req_e r);
    return (r == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/pmem_arbiter_arb_rr2.sv
// Two-way round-robin arbiter; a tie goes to whichever side was not granted last.
module arb_rr2
  import pmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output req_e       last_grant_o
);

  req_e last_grant_q;
  req_e last_grant_d;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = req_onehot(other_req(last_grant_q));
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance_i && (grant_o != 2'b00)) begin
      last_grant_d = grant_o[REQ_D] ? REQ_D : REQ_I;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= REQ_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/pmem_arbiter_line_reg.sv
// Cache-line wide load-enable register, cleared by synchronous reset.
module line_reg #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache,
// registering the winning request onto pmem and holding each side's returned line.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_e        state_q, state_d;
  logic              op_write_q, op_write_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
  logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;

  logic [1:0]        req;
  logic [1:0]        grant;
  logic              advance;
  req_e              last_grant;
  logic [1:0]        rdata_load;
  logic [LINE_W-1:0] rdata_q [2];

  assign req     = {d_read | d_write, i_read};
  assign advance = (state_q == IDLE) && (req != 2'b00);

  arb_rr2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .advance_i    (advance),
    .grant_o      (grant),
    .last_grant_o (last_grant)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    line_reg #(.W(LINE_W)) u_line (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (rdata_load[gi]),
      .d_i    (pmem_rdata),
      .q_o    (rdata_q[gi])
    );
  end

  always_comb begin
    state_d        = state_q;
    op_write_d     = op_write_q;
    pmem_read_d    = pmem_read_q;
    pmem_write_d   = pmem_write_q;
    pmem_address_d = pmem_address_q;
    pmem_wdata_d   = pmem_wdata_q;
    i_resp_d       = 1'b0;
    d_resp_d       = 1'b0;
    rdata_load     = 2'b00;
    case (state_q)
      IDLE: begin
        // A simultaneous read+write from the D side resolves to the write.
        if (grant[REQ_D]) begin
          state_d        = BUSY_D;
          op_write_d     = d_write;
          pmem_read_d    = ~d_write;
          pmem_write_d   = d_write;
          pmem_address_d = d_address;
          pmem_wdata_d   = d_wdata;
        end else if (grant[REQ_I]) begin
          state_d        = BUSY_I;
          op_write_d     = 1'b0;
          pmem_read_d    = 1'b1;
          pmem_write_d   = 1'b0;
          pmem_address_d = i_address;
        end
      end
      BUSY_I: begin
        if (pmem_resp) begin
          state_d           = DONE_I;
          pmem_read_d       = 1'b0;
          pmem_write_d      = 1'b0;
          rdata_load[REQ_I] = 1'b1;
          i_resp_d          = 1'b1;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          state_d           = DONE_D;
          pmem_read_d       = 1'b0;
          pmem_write_d      = 1'b0;
          rdata_load[REQ_D] = ~op_write_q;
          d_resp_d          = 1'b1;
        end
      end
      DONE_I, DONE_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      op_write_q     <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_write_q     <= op_write_d;
      pmem_read_q    <= pmem_read_d;
      pmem_write_q   <= pmem_write_d;
      pmem_address_q <= pmem_address_d;
      pmem_wdata_q   <= pmem_wdata_d;
      i_resp_q       <= i_resp_d;
      d_resp_q       <= d_resp_d;
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;
  assign i_rdata      = rdata_q[REQ_I];
  assign d_rdata      = rdata_q[REQ_D];

`ifndef SYNTHESIS
  a_d_read_write_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) !(d_read && d_write));

  a_tie_alternates: assert property (
    @(posedge clk) disable iff (!rst_n)
    ((state_q == IDLE) && (req == 2'b11)) |-> (grant == req_onehot(other_req(last_grant))));
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: directed scenarios plus a randomized run
// compared against a transaction-level arbitration model.
module tb_pmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int w = 0; w < LINE_W / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Completes the transaction currently on pmem: resp arrives in the lat-th BUSY cycle.
  task automatic serve(input int lat, input logic [LINE_W-1:0] data);
    $display("[TB] txn %s addr=%h lat=%0d", pmem_write ? "write" : "read", pmem_address, lat);
    repeat (lat - 1) tick();
    pmem_rdata = data;
    pmem_resp  = 1'b1;
    tick();
    pmem_resp  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_read = 1'b1; i_address = 32'hDEAD_BEEF;
    d_write = 1'b1; d_address = 32'h1234_5678; d_wdata = rand_line();
    pmem_resp = 1'b1; pmem_rdata = rand_line();
    tick();
    tests++; if (pmem_read !== 1'b0) begin fails++; $display("FAIL reset_pmem_read: got %b expected 0", pmem_read); end
    tests++; if (pmem_write !== 1'b0) begin fails++; $display("FAIL reset_pmem_write: got %b expected 0", pmem_write); end
    tests++; if (pmem_address !== '0) begin fails++; $display("FAIL reset_pmem_address: got %h expected 0", pmem_address); end
    tests++; if (pmem_wdata !== '0) begin fails++; $display("FAIL reset_pmem_wdata: got %h expected 0", pmem_wdata); end
    tests++; if ({i_resp, d_resp} !== 2'b00) begin fails++; $display("FAIL reset_resp: got %b expected 00", {i_resp, d_resp}); end
    tests++; if (i_rdata !== '0) begin fails++; $display("FAIL reset_i_rdata: got %h expected 0", i_rdata); end
    tests++; if (d_rdata !== '0) begin fails++; $display("FAIL reset_d_rdata: got %h expected 0", d_rdata); end
    clear_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_i_read();
    logic [LINE_W-1:0] a5;
    a5 = {(LINE_W/8){8'hA5}};
    do_reset();
    i_read = 1'b1; i_address = 32'h0000_1000;
    tick();
    tests++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL single_pmem_read: got %b expected 1", pmem_read); end
    tests++; if (pmem_address !== 32'h0000_1000) begin fails++; $display("FAIL single_address: got %h expected 00001000", pmem_address); end
    tests++; if (pmem_write !== 1'b0) begin fails++; $display("FAIL single_pmem_write: got %b expected 0", pmem_write); end
    tick();
    tick();
    tests++; if ({pmem_read, i_resp} !== 2'b10) begin fails++; $display("FAIL single_wait: got %b expected 10", {pmem_read, i_resp}); end
    pmem_rdata = a5; pmem_resp = 1'b1;
    $display("[TB] txn read addr=%h lat=3", pmem_address);
    tick();
    pmem_resp = 1'b0; i_read = 1'b0;
    tests++; if (i_resp !== 1'b1) begin fails++; $display("FAIL single_i_resp: got %b expected 1", i_resp); end
    tests++; if (i_rdata !== a5) begin fails++; $display("FAIL single_i_rdata: got %h expected %h", i_rdata, a5); end
    tests++; if (pmem_read !== 1'b0) begin fails++; $display("FAIL single_strobe_clear: got %b expected 0", pmem_read); end
    for (int k = 0; k < 10; k++) begin
      tick();
      tests++; if ({i_resp, pmem_read} !== 2'b00) begin fails++; $display("FAIL single_idle_quiet: got %b expected 00", {i_resp, pmem_read}); end
      tests++; if (i_rdata !== a5) begin fails++; $display("FAIL single_rdata_hold: got %h expected %h", i_rdata, a5); end
    end
  endtask

  task automatic test_alternation();
    logic [LINE_W-1:0] ld, li;
    ld = rand_line(); li = rand_line();
    do_reset();
    i_read = 1'b1; i_address = 32'h100;
    d_read = 1'b1; d_address = 32'h200;
    tick();
    tests++; if (pmem_address !== 32'h200) begin fails++; $display("FAIL alt_first_d: got %h expected 00000200", pmem_address); end
    serve(2, ld);
    tests++; if ({d_resp, i_resp} !== 2'b10) begin fails++; $display("FAIL alt_d_resp: got %b expected 10", {d_resp, i_resp}); end
    tests++; if (d_rdata !== ld) begin fails++; $display("FAIL alt_d_rdata: got %h expected %h", d_rdata, ld); end
    d_read = 1'b0;
    tick();
    tests++; if (pmem_read !== 1'b0) begin fails++; $display("FAIL alt_done_gap: got %b expected 0", pmem_read); end
    tick();
    tests++; if ({pmem_read, pmem_address} !== {1'b1, 32'h100}) begin fails++; $display("FAIL alt_then_i: got %b/%h expected 1/00000100", pmem_read, pmem_address); end
    serve(3, li);
    tests++; if ({i_resp, d_resp} !== 2'b10) begin fails++; $display("FAIL alt_i_resp: got %b expected 10", {i_resp, d_resp}); end
    tests++; if (i_rdata !== li) begin fails++; $display("FAIL alt_i_rdata: got %h expected %h", i_rdata, li); end
    i_address = 32'h180;
    d_read = 1'b1; d_address = 32'h300;
    tick();
    tick();
    tests++; if (pmem_address !== 32'h300) begin fails++; $display("FAIL alt_second_tie_d: got %h expected 00000300", pmem_address); end
    serve(1, rand_line());
    d_address = 32'h340;
    tick();
    tick();
    tests++; if (pmem_address !== 32'h180) begin fails++; $display("FAIL alt_third_tie_i: got %h expected 00000180", pmem_address); end
    serve(1, rand_line());
    clear_inputs();
    tick();
  endtask

  task automatic test_writeback();
    logic [LINE_W-1:0] l5a, wd;
    l5a = {(LINE_W/8){8'h5A}};
    wd  = {(LINE_W/32){32'h1234_5678}};
    do_reset();
    d_read = 1'b1; d_address = 32'h80;
    tick();
    serve(1, l5a);
    d_read = 1'b0;
    tick();
    d_write = 1'b1; d_address = 32'h40; d_wdata = wd;
    pmem_rdata = {LINE_W{1'b1}};
    tick();
    $display("[TB] txn write addr=%h lat=5", pmem_address);
    for (int k = 0; k < 5; k++) begin
      tests++; if ({pmem_write, pmem_read} !== 2'b10) begin fails++; $display("FAIL wb_strobes: got %b expected 10", {pmem_write, pmem_read}); end
      tests++; if (pmem_address !== 32'h40) begin fails++; $display("FAIL wb_address: got %h expected 00000040", pmem_address); end
      tests++; if (pmem_wdata !== wd) begin fails++; $display("FAIL wb_wdata: got %h expected %h", pmem_wdata, wd); end
      d_address = $urandom; d_wdata = rand_line();
      if (k == 4) pmem_resp = 1'b1;
      tick();
    end
    pmem_resp = 1'b0; d_write = 1'b0;
    tests++; if (d_resp !== 1'b1) begin fails++; $display("FAIL wb_d_resp: got %b expected 1", d_resp); end
    tests++; if (d_rdata !== l5a) begin fails++; $display("FAIL wb_d_rdata_kept: got %h expected %h", d_rdata, l5a); end
    tests++; if (pmem_write !== 1'b0) begin fails++; $display("FAIL wb_strobe_clear: got %b expected 0", pmem_write); end
    tick();
    tests++; if (d_resp !== 1'b0) begin fails++; $display("FAIL wb_resp_once: got %b expected 0", d_resp); end
  endtask

  task automatic test_drop_mid_busy();
    logic [LINE_W-1:0] li;
    int pulses;
    li = rand_line();
    do_reset();
    i_read = 1'b1; i_address = 32'h2000;
    tick();
    i_read = 1'b0;
    tests++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL drop_started: got %b expected 1", pmem_read); end
    serve(3, li);
    tests++; if (i_resp !== 1'b1) begin fails++; $display("FAIL drop_i_resp: got %b expected 1", i_resp); end
    tests++; if (i_rdata !== li) begin fails++; $display("FAIL drop_i_rdata: got %h expected %h", i_rdata, li); end
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (i_resp === 1'b1 || pmem_read === 1'b1 || pmem_write === 1'b1) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL drop_no_reissue: got %0d busy cycles expected 0", pulses); end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    d_read = 1'b1; d_address = 32'h300;
    tick();
    tests++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL rstbusy_started: got %b expected 1", pmem_read); end
    rst_n = 1'b0; d_read = 1'b0;
    tick();
    tests++; if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin fails++; $display("FAIL rstbusy_bits: got %b expected 0000", {pmem_read, pmem_write, i_resp, d_resp}); end
    tests++; if (pmem_address !== '0) begin fails++; $display("FAIL rstbusy_address: got %h expected 0", pmem_address); end
    rst_n = 1'b1; pmem_resp = 1'b1; pmem_rdata = rand_line();
    tick();
    pmem_resp = 1'b0;
    tests++; if (d_resp !== 1'b0) begin fails++; $display("FAIL rstbusy_late_resp: got %b expected 0", d_resp); end
    tests++; if (d_rdata !== '0) begin fails++; $display("FAIL rstbusy_d_rdata: got %h expected 0", d_rdata); end
    i_read = 1'b1; i_address = 32'h500;
    d_read = 1'b1; d_address = 32'h600;
    tick();
    tests++; if (pmem_address !== 32'h600) begin fails++; $display("FAIL rstbusy_tie_d: got %h expected 00000600", pmem_address); end
    i_read = 1'b0; d_read = 1'b0;
    serve(1, rand_line());
    tick();
  endtask

  task automatic test_spurious_resp();
    logic [LINE_W-1:0] li, ld;
    li = rand_line(); ld = rand_line();
    do_reset();
    i_read = 1'b1; i_address = 32'h10;
    tick();
    serve(2, li);
    i_read = 1'b0;
    tick();
    d_read = 1'b1; d_address = 32'h20;
    tick();
    serve(2, ld);
    d_read = 1'b0;
    tick();
    pmem_resp = 1'b1; pmem_rdata = {LINE_W{1'b1}};
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if ({i_resp, d_resp, pmem_read, pmem_write} !== 4'b0000) begin fails++; $display("FAIL spur_quiet: got %b expected 0000", {i_resp, d_resp, pmem_read, pmem_write}); end
      tests++; if (i_rdata !== li) begin fails++; $display("FAIL spur_i_rdata: got %h expected %h", i_rdata, li); end
      tests++; if (d_rdata !== ld) begin fails++; $display("FAIL spur_d_rdata: got %h expected %h", d_rdata, ld); end
    end
    pmem_resp = 1'b0;
  endtask

  // Transaction-level model: a free port grants the sampled requester(s) by
  // alternating priority; each grant is one pmem access answered by the bench.
  task automatic test_random(input int ncycles);
    int phase;  // 0 = port free, 1 = access outstanding, 2 = completion cycle
    int lat;
    int ntx;
    bit own_d, exp_wr, exp_strobe, last_d, exp_i_resp, exp_d_resp;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] exp_wdata, exp_i_rdata, exp_d_rdata;
    do_reset();
    phase = 0; lat = 0; ntx = 0; last_d = 1'b0; own_d = 1'b0; exp_wr = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_i_rdata = '0; exp_d_rdata = '0;
    for (int c = 0; c < ncycles; c++) begin
      tick();
      exp_strobe = 1'b0; exp_i_resp = 1'b0; exp_d_resp = 1'b0;
      if (phase == 0) begin
        if (i_read || d_read || d_write) begin
          if (i_read && (d_read || d_write)) own_d = !last_d;
          else own_d = d_read || d_write;
          exp_wr     = own_d && d_write;
          exp_addr   = own_d ? d_address : i_address;
          exp_wdata  = d_wdata;
          last_d     = own_d;
          exp_strobe = 1'b1;
          phase      = 1;
          lat        = $urandom_range(0, 4);
        end
      end else if (phase == 1) begin
        if (pmem_resp) begin
          if (own_d) begin
            exp_d_resp = 1'b1;
            if (!exp_wr) exp_d_rdata = pmem_rdata;
          end else begin
            exp_i_resp  = 1'b1;
            exp_i_rdata = pmem_rdata;
          end
          phase = 2;
          ntx++;
          $display("[TB] rnd txn %0d %s %s addr=%h", ntx, own_d ? "D" : "I", exp_wr ? "write" : "read", exp_addr);
        end else begin
          exp_strobe = 1'b1;
        end
      end else begin
        phase = 0;
      end
      tests++; if (pmem_read !== (exp_strobe && !exp_wr)) begin fails++; $display("FAIL rnd_pmem_read c%0d: got %b expected %b", c, pmem_read, exp_strobe && !exp_wr); end
      tests++; if (pmem_write !== (exp_strobe && exp_wr)) begin fails++; $display("FAIL rnd_pmem_write c%0d: got %b expected %b", c, pmem_write, exp_strobe && exp_wr); end
      if (exp_strobe) begin
        tests++; if (pmem_address !== exp_addr) begin fails++; $display("FAIL rnd_address c%0d: got %h expected %h", c, pmem_address, exp_addr); end
      end
      if (exp_strobe && exp_wr) begin
        tests++; if (pmem_wdata !== exp_wdata) begin fails++; $display("FAIL rnd_wdata c%0d: got %h expected %h", c, pmem_wdata, exp_wdata); end
      end
      tests++; if ({i_resp, d_resp} !== {exp_i_resp, exp_d_resp}) begin fails++; $display("FAIL rnd_resp c%0d: got %b expected %b", c, {i_resp, d_resp}, {exp_i_resp, exp_d_resp}); end
      tests++; if (i_rdata !== exp_i_rdata) begin fails++; $display("FAIL rnd_i_rdata c%0d: got %h expected %h", c, i_rdata, exp_i_rdata); end
      tests++; if (d_rdata !== exp_d_rdata) begin fails++; $display("FAIL rnd_d_rdata c%0d: got %h expected %h", c, d_rdata, exp_d_rdata); end

      pmem_resp = 1'b0;
      if (phase == 1) begin
        if (lat == 0) begin
          pmem_resp = 1'b1; pmem_rdata = rand_line();
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        pmem_resp = 1'b1; pmem_rdata = rand_line();
      end

      if (i_read) begin
        if (i_resp) begin
          if ($urandom_range(0, 1) == 0) i_read = 1'b0;
          else i_address = $urandom;
        end else if ($urandom_range(0, 31) == 0) begin
          i_read = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_read = 1'b1; i_address = $urandom;
      end

      if (d_read || d_write) begin
        if (d_resp && $urandom_range(0, 1) == 0) begin
          d_read = 1'b0; d_write = 1'b0;
        end else if (d_resp) begin
          d_write = 1'($urandom_range(0, 1)); d_read = !d_write;
          d_address = $urandom; d_wdata = rand_line();
        end else if ($urandom_range(0, 31) == 0) begin
          d_read = 1'b0; d_write = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        d_write = 1'($urandom_range(0, 1)); d_read = !d_write;
        d_address = $urandom; d_wdata = rand_line();
      end
    end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_i_read();
    test_alternation();
    test_writeback();
    test_drop_mid_busy();
    test_reset_mid_busy();
    test_spurious_resp();
    test_random(1500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory line port between the I-cache (read-only) and the D-cache (read/write).
- Arbitrates between them with 2-way round-robin priority.
- Registers the granted request onto pmem and returns a one-cycle resp to the winner.
- Holds each requester's returned line in its own register, so data stays stable while that requester's pipeline is stalled.
- Sits between the cache pair and the pmem synchronizer / physical memory.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 256, cache line width in bits

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
i_read  in  1  I-cache line read request, level, held until i_resp
i_address  in  ADDR_W  I-cache line address
i_rdata  out  LINE_W  line returned to I-cache, held until next I fill
i_resp  out  1  one-cycle completion pulse to I-cache
d_read  in  1  D-cache line read request, level
d_write  in  1  D-cache writeback request, level
d_address  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache writeback data
d_rdata  out  LINE_W  line returned to D-cache, held until next D fill
d_resp  out  1  one-cycle completion pulse to D-cache
pmem_read  out  1  registered read strobe to pmem
pmem_write  out  1  registered write strobe to pmem
pmem_address  out  ADDR_W  registered address
pmem_wdata  out  LINE_W  registered write data
pmem_rdata  in  LINE_W  pmem read data, valid with pmem_resp
pmem_resp  in  1  pmem completion

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- On a rising edge with rst_n=0:
  - state=IDLE, last_grant=I.
  - All pmem_* outputs, i_resp, d_resp, i_rdata and d_rdata are 0.
  - Applies mid-transaction: any in-flight pmem access is abandoned, and a later pmem_resp is ignored.
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- IDLE:
  - d_req = d_read|d_write.
  - Only one requester active -> grant it.
  - Both active -> grant the requester that is not last_grant. First tie after reset goes to D.
  - On the grant edge, latch op, address and wdata into the pmem output registers, update last_grant, and go to BUSY_x.
  - Latency: a request sampled in cycle N gives a pmem strobe in cycle N+1.
- BUSY_x:
  - pmem_* outputs are held constant. The requester's inputs are not re-sampled.
  - On pmem_resp=1: capture pmem_rdata into x_rdata (only for reads), clear the pmem strobes, go to DONE_x.
  - Requester dropping its request mid-BUSY does not abort; the transaction completes and resp is still pulsed.
- DONE_x:
  - x_resp=1 for exactly this one cycle, then go to IDLE.
  - x_rdata is valid from this cycle and holds until the next read completion for x.
  - Writebacks leave d_rdata unchanged.
  - Latency: pmem_resp in cycle M gives x_resp in cycle M+1.
- Requester protocol:
  - A requester sees x_resp and deasserts its request at the next edge.
  - A request still high in the cycle after DONE is treated as a new request.
- Illegal combination: d_read&d_write -> write wins. A simulation assertion flags it.
- pmem_resp is ignored in IDLE and DONE states.
- No combinational path from any input to any output; every output is registered.

Decomposition:
- Package pmem_arb_pkg:
  - LINE_W and ADDR_W defaults.
  - State enum: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
  - Requester enum: REQ_I, REQ_D.
- Sub-module arb_rr2:
  - Inputs: req[1:0], an advance strobe.
  - Outputs: one-hot grant and the last_grant register.
  - Reset state last_grant=REQ_I.
- i_rdata and d_rdata latches use the existing register module, with load = (state==BUSY_x & pmem_resp & op==read).

Test Plan:
- Reset, then single I read of 0x0000_1000; pmem_resp after 3 cycles with rdata=0xA5..A5:
  - pmem_read is high from cycle 1.
  - i_resp pulses 1 cycle after pmem_resp.
  - i_rdata=0xA5..A5 and stays so for 10 idle cycles.
- Simultaneous i_read(0x100) and d_read(0x200) after reset:
  - D is served first.
  - On D completion, I is granted (pmem_address=0x100).
  - Then with both re-asserted, D wins again: strict alternation.
- D writeback to 0x0040, wdata=0x1234..:
  - pmem_write=1, pmem_address=0x40, pmem_wdata stable across 5 wait cycles.
  - d_resp pulses once; d_rdata is unchanged.
- I request dropped during BUSY_I:
  - pmem access still completes.
  - i_resp pulses once; no second pmem transaction is issued.
- rst_n=0 during BUSY_D, then pmem_resp arrives:
  - All outputs are 0 after the edge.
  - The late pmem_resp produces no d_resp; the next tie grants D.
- pmem_resp asserted spuriously in IDLE with pmem_rdata=0xFF..FF:
  - No resp pulse; i_rdata and d_rdata are unchanged.
